// File: rtl/rle_decoder_if.sv
// rle_decoder_if: bundles the write, read and status signals of the
// run-length decoder.
//   slave  modport - decoder side (takes pairs and rd_en, drives the stream and status)
//   master modport - producer/consumer side (the mirror image)
// Signals:
//   CS                 chip select, gates every write, pop and consume
//   wr_en/wr_din/wr_cin  write request with symbol and repeat count
//   wr_full            pair FIFO holds DEPTH pairs
//   rd_en              consumer ready
//   rd_out/rd_valid/rd_last  output symbol, valid flag, last beat of run
//   empty              nothing stored and no run in progress
//   ovf                sticky overflow flag
interface rle_decoder_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  logic          CS;
  logic          wr_en;
  logic [DW-1:0] wr_din;
  logic [CW-1:0] wr_cin;
  logic          wr_full;
  logic          rd_en;
  logic [DW-1:0] rd_out;
  logic          rd_valid;
  logic          rd_last;
  logic          empty;
  logic          ovf;

  modport slave (
    input  CS, wr_en, wr_din, wr_cin, rd_en,
    output wr_full, rd_out, rd_valid, rd_last, empty, ovf
  );

  modport master (
    output CS, wr_en, wr_din, wr_cin, rd_en,
    input  wr_full, rd_out, rd_valid, rd_last, empty, ovf
  );
endinterface

// File: rtl/rle_decoder.sv
// rle_decoder: run-length decoder. (symbol, count) pairs are written into a
// DEPTH-entry FIFO; an IDLE/RUN expander pops them and emits each symbol
// count times on a valid/ready stream with no bubble between runs.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset, flushes FIFO and expander
//   bus  - rle_decoder_if.slave (write side, read stream, status flags)
module rle_decoder #(
  parameter int DW    = 8,
  parameter int CW    = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           CLK,
  input  logic           RST,
  rle_decoder_if.slave   bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CW-1:0] REM_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_sym [DEPTH];
  logic [CW-1:0] mem_cnt [DEPTH];

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] rd_out_q, rd_out_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;

  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          wr_req_s;
  logic          wr_accept_s;
  logic          wr_reject_s;
  logic          consume_s;
  logic          last_beat_s;
  logic          pop_s;

  // FIFO status from the extra pointer bit: same address with differing wrap bits means full.
  always_comb begin
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

  // Write-side qualification; zero-count pairs are neither stored nor flagged.
  always_comb begin
    wr_req_s    = bus.CS && bus.wr_en && (bus.wr_cin != {CW{1'b0}});
    wr_accept_s = wr_req_s && !fifo_full_s;
    wr_reject_s = wr_req_s && fifo_full_s;
    consume_s   = bus.CS && rd_valid_q && bus.rd_en;
    last_beat_s = (rem_q == REM_ONE);
  end

  // Pop decision: fill an idle expander, or reload on the last beat so runs stay contiguous.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE:    pop_s = bus.CS && !fifo_empty_s;
      RUN:     pop_s = consume_s && last_beat_s && !fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Next-state logic for the expander.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (consume_s && last_beat_s && !pop_s) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Expander datapath: load on pop, count down on consume, otherwise hold.
  always_comb begin
    rd_out_d   = rd_out_q;
    rem_d      = rem_q;
    rd_valid_d = rd_valid_q;
    if (pop_s) begin
      rd_out_d   = mem_sym[rd_ptr_q[AW-1:0]];
      rem_d      = mem_cnt[rd_ptr_q[AW-1:0]];
      rd_valid_d = 1'b1;
    end else if (consume_s) begin
      rem_d      = rem_q - REM_ONE;
      rd_valid_d = !last_beat_s;
    end else begin
      rd_valid_d = rd_valid_q;
    end
  end

  // Pointer advance and sticky overflow.
  always_comb begin
    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    ovf_d = ovf_q || wr_reject_s;
  end

  // Pair storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge CLK) begin
    if (wr_accept_s) begin
      mem_sym[wr_ptr_q[AW-1:0]] <= bus.wr_din;
      mem_cnt[wr_ptr_q[AW-1:0]] <= bus.wr_cin;
    end
  end

  // State and control registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      wr_ptr_q   <= {(AW+1){1'b0}};
      rd_ptr_q   <= {(AW+1){1'b0}};
      rd_out_q   <= {DW{1'b0}};
      rem_q      <= {CW{1'b0}};
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_out_q   <= rd_out_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.wr_full  = fifo_full_s;
  assign bus.rd_out   = rd_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_valid_q && last_beat_s;
  assign bus.empty    = fifo_empty_s && !rd_valid_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: doc/rle_decoder.md
# rle_decoder

Parametrised run-length decoder. Accepts (symbol, repeat-count) pairs, buffers them in a pair FIFO, and emits each symbol `count` times on a valid/ready output stream. It adds zero-count filtering, output backpressure, run-end marking, and full/overflow status. It sits between the compressed-stream writer and the symbol consumer.

## Interface

**Parameters**
- DW, 8, symbol width
- CW, 4, repeat-count width; max run is 2^CW-1
- DEPTH, 8, pair FIFO depth; must equal 2^AW
- AW, 3, FIFO address width

**Ports**
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-high
- CS  in  1  chip select; gates every write, pop and consume
- wr_en  in  1  write request
- wr_din  in  DW  symbol
- wr_cin  in  CW  repeat count
- wr_full  out  1  FIFO holds DEPTH pairs
- rd_en  in  1  consumer ready
- rd_out  out  DW  current output symbol
- rd_valid  out  1  rd_out is valid
- rd_last  out  1  current beat is the last of its run
- empty  out  1  FIFO empty and no run in progress
- ovf  out  1  sticky overflow flag

## Operation

**Write side**
- A write is accepted when CS & wr_en & !wr_full & wr_cin!=0. The pair goes to the tail and the write pointer advances.
- wr_cin==0: the pair is discarded silently. No storage, no ovf.
- CS & wr_en & wr_full & wr_cin!=0: the pair is dropped and ovf is set to 1. ovf stays 1 until RST.
- Pointers are AW+1 bits wide. wr_full and the FIFO-empty condition come from MSB/address comparison and wrap naturally.

**Expander FSM, states IDLE and RUN**
- Registers: rd_out, rd_valid, rem (CW bits).
- IDLE: if CS and the FIFO is not empty, pop the head and load rd_out←symbol, rem←count, rd_valid←1, then go to RUN.
- RUN: a beat is consumed when CS & rd_valid & rd_en.
  - On consume with rem>1: rem←rem-1.
  - On consume with rem==1 and FIFO not empty: pop the next pair into rd_out/rem in the same edge and stay in RUN. There is no bubble.
  - On consume with rem==1 and FIFO empty: rd_valid←0, go to IDLE. rd_out holds its last value.
- Without a consume, rd_out, rem and rd_valid hold.
- rd_last = rd_valid & (rem==1), combinational.
- empty = FIFO empty & !rd_valid.
- CS low: writes are ignored and the expander freezes (no pop, no consume). Outputs hold.

**Simultaneous events**
- Write and pop in the same cycle: both happen and occupancy is unchanged.
- Write while full with a pop in the same cycle: the write is still rejected (wr_full uses pre-edge occupancy) and ovf is set.
- Write to an empty FIFO: there is no fall-through. The pop sees the pair one cycle later.

**Reset**
- Reset values: rd_out=0, rd_valid=0, rd_last=0, rem=0, wr_full=0, empty=1, ovf=0, pointers=0, state=IDLE.
- Reset asserted mid-run or with a non-empty FIFO flushes everything immediately.

## Timing

- Write-to-first-beat latency: a pair accepted at edge N is popped at edge N+1. rd_valid is high after N+1 (2 cycles) when the expander is idle.
- With rd_en held high, a run of count c occupies exactly c consecutive cycles. Consecutive runs are contiguous while the FIFO is non-empty.
- Throughput: 1 symbol per cycle. Pair input rate is sustainable while mean count ≥1.
- wr_full and ovf update on the edge after the causing write.
- empty drops on the edge after the first write when the block is idle.

## Test plan

1. Reset: hold RST with random inputs. Required: rd_out=0, rd_valid=0, rd_last=0, wr_full=0, empty=1, ovf=0. Release and drive idle inputs: outputs stay unchanged.
2. Single run: write (97,3) with rd_en=1. Required: rd_valid high 2 cycles after the write edge; rd_out=97 for 3 consecutive cycles; rd_last only on the 3rd; then rd_valid=0 and empty=1.
3. Stream: back-to-back writes (97,3),(98,2),(99,1),(100,4),(101,2),(99,5),(100,4),(97,3) with rd_en=1. Required: 24 contiguous beats in order, with no bubbles and rd_last at each run end.
4. Backpressure: stream (98,2),(99,1) with rd_en toggling 1,0,0,1,1. Required: each symbol holds while rd_en=0, and beat counts are exactly 2 and 1.
5. Full/overflow: rd_en=0, CS=1; write 9 pairs (10,1)..(18,1). Required: the first pair sits in the expander, the FIFO fills, wr_full=1 after the 9th accepted-or-pending write, any further write is dropped and ovf=1. Then set rd_en=1: the stored pairs drain in order, wr_full clears, and ovf stays 1.
6. Zero count, CS, reset: write (101,0). Required: not stored, empty stays 1, ovf=0. During a (100,4) run, drop CS for 3 cycles: rd_out/rem frozen, then the remaining beats resume. Assert RST mid-run: all outputs return to reset values at once.
